// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial WIDTH-bit a-b (optionally a+b with SUB_ADD_MODE_EN): 4-bit CLA slice per clock, carry kept in a flop.
// Latency: start sampled at edge k, done pulses after edge k+WIDTH/4; one result per WIDTH/4+1 cycles back-to-back.
// Backpressure: none; start is ignored while busy, and diff is only valid when qualified by done.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_a, r_bn, r_diff;
    logic              r_carry, r_bout, r_ovf;
    logic [IDXW-1:0]   r_idx;
    logic              w_accept, w_last, w_sub_in, w_sub;
    logic [3:0]        w_an, w_bn, w_p, w_g, w_sum;
    logic              w_c1, w_c2, w_c3, w_c4;

`ifdef SUB_ADD_MODE_EN
    logic r_sub;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_sub <= 1'b1;
        else if (w_accept) r_sub <= mode;
    end
    assign w_sub_in = mode;
    assign w_sub    = r_sub;
`else
    assign w_sub_in = 1'b1;
    assign w_sub    = 1'b1;
`endif

    assign w_accept = start & (r_state != S_RUN);
    assign w_last   = (r_idx == IDXW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_an = 4'h0;
        w_bn = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_an = r_a[i*4 +: 4];
                w_bn = r_bn[i*4 +: 4];
            end
        end
    end

    // Full 4-bit lookahead; the nibble's carry-in comes from the previous cycle
    assign w_p  = w_an ^ w_bn;
    assign w_g  = w_an & w_bn;
    assign w_c1 = w_g[0] | (w_p[0] & r_carry);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_sum = w_p ^ {w_c3, w_c2, w_c1, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_bn    <= '0;
            r_diff  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_bn    <= w_sub_in ? ~b : b;
            r_carry <= w_sub_in;
            r_idx   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (r_idx == IDXW'(i)) r_diff[i*4 +: 4] <= w_sum;
            end
            r_carry <= w_c4;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_bout <= w_sub ? ~w_c4 : w_c4;
                // bn_r already holds the effective second operand in both modes
                r_ovf  <= (r_a[WIDTH-1] == r_bn[WIDTH-1]) & (w_sum[3] != r_a[WIDTH-1]);
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
